// File: rtl/telemetry_sched_if.sv
// Handshake and data bundle between the telemetry scheduler, the sensor registers and the UART
// transmitter. The master side supplies readings and tx_done; the slave side is the scheduler.
interface telemetry_sched_if;
  logic        en;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        ovr;

  modport master (
    output en,
    output batt,
    output curr,
    output torque,
    output tx_done,
    input  trmt,
    input  tx_data,
    input  busy,
    input  ovr
  );

  modport slave (
    input  en,
    input  batt,
    input  curr,
    input  torque,
    input  tx_done,
    output trmt,
    output tx_data,
    output busy,
    output ovr
  );
endinterface

// File: rtl/telemetry_sched.sv
// Periodic telemetry scheduler: snapshots battery/current/torque on a free-running tick and
// sends an 8-byte framed packet to the UART transmitter using its trmt/tx_done handshake.
module telemetry_sched #(
  parameter int unsigned FAST_SIM = 1
) (
  input logic              clk,
  input logic              rst,
  telemetry_sched_if.slave tel
);

  localparam int unsigned TmrW = (FAST_SIM != 0) ? 12 : 20;
  localparam logic [TmrW-1:0] TmrOne = 1;

  // StLoad is the one-cycle register-update slot between a byte's tx_done and the next trmt.
  typedef enum logic [1:0] {
    StIdle,
    StXmit,
    StWait,
    StLoad
  } state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q;
  logic              tick;
  logic [2:0]        idx_q, idx_d;
  logic [11:0]       batt_s_q, batt_s_d;
  logic [11:0]       curr_s_q, curr_s_d;
  logic [11:0]       torque_s_q, torque_s_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              trmt_q;
  logic              busy_q;
  logic              ovr_q, ovr_d;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  i,
                                           input logic [11:0] b,
                                           input logic [11:0] c,
                                           input logic [11:0] t);
    logic [7:0] byte_v;
    case (i)
      3'd0:    byte_v = 8'hAA;
      3'd1:    byte_v = 8'h55;
      3'd2:    byte_v = {4'h0, b[11:8]};
      3'd3:    byte_v = b[7:0];
      3'd4:    byte_v = {4'h0, c[11:8]};
      3'd5:    byte_v = c[7:0];
      3'd6:    byte_v = {4'h0, t[11:8]};
      default: byte_v = t[7:0];
    endcase
    return byte_v;
  endfunction

  assign tick = &tmr_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    batt_s_d   = batt_s_q;
    curr_s_d   = curr_s_q;
    torque_s_d = torque_s_q;
    tx_data_d  = tx_data_q;
    ovr_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick && tel.en) begin
          batt_s_d   = tel.batt;
          curr_s_d   = tel.curr;
          torque_s_d = tel.torque;
          idx_d      = 3'd0;
          tx_data_d  = 8'hAA;
          state_d    = StXmit;
        end
      end
      StXmit: begin
        state_d = StWait;
      end
      StWait: begin
        if (tel.tx_done) begin
          if (idx_q == 3'd7) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        // tx_data changes together with trmt so it stays stable across a whole byte.
        tx_data_d = pkt_byte(idx_q, batt_s_q, curr_s_q, torque_s_q);
        state_d   = StXmit;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (tick && tel.en && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      idx_q      <= 3'd0;
      batt_s_q   <= 12'h000;
      curr_s_q   <= 12'h000;
      torque_s_q <= 12'h000;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_q + TmrOne;
      idx_q      <= idx_d;
      batt_s_q   <= batt_s_d;
      curr_s_q   <= curr_s_d;
      torque_s_q <= torque_s_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= (state_d == StXmit);
      busy_q     <= (state_d != StIdle);
      ovr_q      <= ovr_d;
    end
  end

  assign tel.trmt    = trmt_q;
  assign tel.tx_data = tx_data_q;
  assign tel.busy    = busy_q;
  assign tel.ovr     = ovr_q;

endmodule

// File: tb/tb_telemetry_sched.sv
// Bench for telemetry_sched: a per-cycle reference timeline built from the packet rules with
// plain arithmetic, a UART model answering trmt after a programmable delay, and directed scenarios.
module tb_telemetry_sched;

  localparam int Period = 4096;

  logic clk = 1'b0;
  logic rst;

  telemetry_sched_if tel();

  telemetry_sched #(.FAST_SIM(1)) dut (
    .clk (clk),
    .rst (rst),
    .tel (tel.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int base_p = 0;
  int uart_delay = 20;
  int stray_cnt = 0;

  // Expected timeline, keyed by cycle index (value of cyc at the negedge).
  logic [7:0] exp_tx[int];
  bit         exp_ovr[int];
  bit         exp_busy[int];
  logic [7:0] tx_hold = 8'h00;

  // UART transmitter model: tx_done for one clock, uart_delay clocks after each trmt.
  int u_cnt = 0;
  int u_seen = 0;
  initial begin
    tel.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tel.tx_done = 1'b0;
      if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) tel.tx_done = 1'b1;
      end
      if (tel.trmt === 1'b1) u_cnt = uart_delay;
      if (u_seen != stray_cnt) begin
        u_seen = stray_cnt;
        tel.tx_done = 1'b1;
      end
    end
  end

  function automatic int tick(input int k);
    return base_p + Period - 1 + Period * k;
  endfunction

  task automatic check_cycle();
    logic e_t;
    logic e_o;
    logic e_b;
    e_t = exp_tx.exists(cyc);
    e_o = exp_ovr.exists(cyc);
    e_b = exp_busy.exists(cyc);
    if (e_t) tx_hold = exp_tx[cyc];
    checks++;
    assert (tel.trmt === e_t) else begin
      errors++;
      $error("FAIL trmt @%0d: got %b want %b", cyc, tel.trmt, e_t);
    end
    checks++;
    assert (tel.tx_data === tx_hold) else begin
      errors++;
      $error("FAIL tx_data @%0d: got %h want %h", cyc, tel.tx_data, tx_hold);
    end
    checks++;
    assert (tel.busy === e_b) else begin
      errors++;
      $error("FAIL busy @%0d: got %b want %b", cyc, tel.busy, e_b);
    end
    checks++;
    assert (tel.ovr === e_o) else begin
      errors++;
      $error("FAIL ovr @%0d: got %b want %b", cyc, tel.ovr, e_o);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  // Packet started by the tick in cycle t, UART answering d clocks after each trmt.
  task automatic plan_packet(input int t, input int d, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] q, output int last);
    logic [7:0] bytes [8];
    bytes = '{8'hAA, 8'h55, {4'h0, b[11:8]}, b[7:0],
              {4'h0, c[11:8]}, c[7:0], {4'h0, q[11:8]}, q[7:0]};
    for (int i = 0; i < 8; i++) exp_tx[t + 1 + i * (d + 2)] = bytes[i];
    last = t + 1 + 7 * (d + 2) + d;
    for (int x = t + 1; x <= last; x++) exp_busy[x] = 1'b1;
    for (int x = t + Period; x <= last; x += Period) exp_ovr[x + 1] = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_tx.delete();
    exp_ovr.delete();
    exp_busy.delete();
    tx_hold = 8'h00;
    repeat (n) step();
    rst = 1'b0;
    base_p = cyc;
  endtask

  task automatic drive_random(output logic [11:0] b, output logic [11:0] c,
                              output logic [11:0] q);
    b = 12'($urandom);
    c = 12'($urandom);
    q = 12'($urandom);
    tel.batt   = b;
    tel.curr   = c;
    tel.torque = q;
  endtask

  initial begin
    logic [11:0] b, c, q;
    int t, d, last;

    rst        = 1'b1;
    tel.en     = 1'b1;
    tel.batt   = 12'hABC;
    tel.curr   = 12'h123;
    tel.torque = 12'h7FF;

    // Reset, first tick and basic packet; live inputs change right after the snapshot.
    uart_delay = 20;
    do_reset(3);
    t = tick(0);
    plan_packet(t, 20, 12'hABC, 12'h123, 12'h7FF, last);
    run_until(t + 2);
    tel.batt   = 12'h000;
    tel.curr   = 12'($urandom);
    tel.torque = 12'($urandom);
    run_until(last + 10);

    // Overrun: long packet spans the next tick, which is dropped with one ovr pulse.
    uart_delay = 600;
    drive_random(b, c, q);
    t = tick(1);
    plan_packet(t, 600, b, c, q, last);
    run_until(t + 1);
    drive_random(b, c, q);
    run_until(last + 1);
    d = 5 + int'($urandom_range(0, 35));
    uart_delay = d;
    drive_random(b, c, q);
    t = tick(3);
    plan_packet(t, d, b, c, q, last);
    run_until(last + 5);

    // Disabled across two ticks, with stray tx_done pulses while idle.
    tel.en = 1'b0;
    run_until(tick(4) + 200);
    stray_cnt++;
    run_until(tick(5) + 50);
    stray_cnt++;
    run_until(tick(6) - 100);

    // Enable dropped after byte 3: packet still completes.
    tel.en = 1'b1;
    d = 5 + int'($urandom_range(0, 35));
    uart_delay = d;
    drive_random(b, c, q);
    t = tick(6);
    plan_packet(t, d, b, c, q, last);
    run_until(t + 1 + 3 * (d + 2) + 1);
    tel.en = 1'b0;
    run_until(last + 5);

    // Reset while waiting on byte 4, then the next packet one full period after release.
    tel.en = 1'b1;
    d = 20 + int'($urandom_range(0, 20));
    uart_delay = d;
    drive_random(b, c, q);
    t = tick(7);
    plan_packet(t, d, b, c, q, last);
    run_until(t + 1 + 4 * (d + 2) + 3);
    do_reset(1);
    d = 5 + int'($urandom_range(0, 35));
    uart_delay = d;
    drive_random(b, c, q);
    t = tick(0);
    plan_packet(t, d, b, c, q, last);
    run_until(last + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
